wvf_burst_sequencer: RTL and testbench

- Sequences one LUT waveform generator in bursts: N waveform periods per burst, R bursts, a programmable idle gap between bursts.
- Drives the generator's enable and its external step trigger.
  - The generator is built with its count and trigger set to external.
  - Its own wait counter is bypassed; this block sets the sample rate.
- Sits between the control middleware (register bank) and the generator instance.

---
 rtl/wvf_burst_sequencer_if.sv | 47 ++++
 rtl/wvf_burst_sequencer.sv | 121 ++++++++++++
 tb/tb_wvf_burst_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/wvf_burst_sequencer_if.sv
// wvf_burst_sequencer_if: register-bank and generator-side signals of the burst sequencer
// Optional macro: WVF_SEQ_ABORT_EN adds abort_i.
// Modports:
//   slave  - sequencer view: start/stop/cfg_*/lut_end (+abort) in; ready/busy/done/burst_cnt/lut_en/lut_step out
//   master - register bank + generator view (directions reversed)
interface wvf_burst_sequencer_if #(
    parameter int PER_WIDTH   = 8,
    parameter int BURST_WIDTH = 8,
    parameter int GAP_WIDTH   = 16,
    parameter int DIV_WIDTH   = 12
);
    logic                   start_i;
    logic                   stop_i;
    logic [PER_WIDTH-1:0]   cfg_periods_i;
    logic [BURST_WIDTH-1:0] cfg_bursts_i;
    logic [GAP_WIDTH-1:0]   cfg_gap_i;
    logic [DIV_WIDTH-1:0]   cfg_step_div_i;
    logic                   lut_end_i;
`ifdef WVF_SEQ_ABORT_EN
    logic                   abort_i;
`endif
    logic                   ready_o;
    logic                   lut_en_o;
    logic                   lut_step_o;
    logic                   busy_o;
    logic                   done_o;
    logic [BURST_WIDTH-1:0] burst_cnt_o;
`ifdef WVF_SEQ_ABORT_EN
    modport slave (
        input  start_i, stop_i, cfg_periods_i, cfg_bursts_i, cfg_gap_i, cfg_step_div_i, lut_end_i, abort_i,
        output ready_o, lut_en_o, lut_step_o, busy_o, done_o, burst_cnt_o
    );
    modport master (
        output start_i, stop_i, cfg_periods_i, cfg_bursts_i, cfg_gap_i, cfg_step_div_i, lut_end_i, abort_i,
        input  ready_o, lut_en_o, lut_step_o, busy_o, done_o, burst_cnt_o
    );
`else
    modport slave (
        input  start_i, stop_i, cfg_periods_i, cfg_bursts_i, cfg_gap_i, cfg_step_div_i, lut_end_i,
        output ready_o, lut_en_o, lut_step_o, busy_o, done_o, burst_cnt_o
    );
    modport master (
        output start_i, stop_i, cfg_periods_i, cfg_bursts_i, cfg_gap_i, cfg_step_div_i, lut_end_i,
        input  ready_o, lut_en_o, lut_step_o, busy_o, done_o, burst_cnt_o
    );
`endif
endinterface

// File: rtl/wvf_burst_sequencer.sv
// wvf_burst_sequencer: runs a LUT waveform generator in bursts of N periods, R bursts, idle gaps between
// Optional macro: WVF_SEQ_ABORT_EN adds bus.abort_i for immediate termination through FIN.
// Ports:
//   clk_sys_i - system clock, rising edge
//   rst_i     - asynchronous active-high reset
//   bus       - wvf_burst_sequencer_if.slave: control/config and lut_end_i in; status, lut_en_o, lut_step_o out
module wvf_burst_sequencer #(
    parameter int PER_WIDTH   = 8,
    parameter int BURST_WIDTH = 8,
    parameter int GAP_WIDTH   = 16,
    parameter int DIV_WIDTH   = 12
) (
    input logic                  clk_sys_i,
    input logic                  rst_i,
    wvf_burst_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, RUN, GAP, FIN} state_t;
    state_t                 state_q, state_d;
    logic [PER_WIDTH-1:0]   per_q, per_d, per_cnt_q, per_cnt_d;
    logic [BURST_WIDTH-1:0] bursts_q, bursts_d, burst_cnt_q, burst_cnt_d, burst_inc;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d, div_cnt_q, div_cnt_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   lut_en_q, lut_en_d, lut_step_q, lut_step_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   abort, wrap, per_end, burst_end, last_burst;
`ifdef WVF_SEQ_ABORT_EN
    assign abort = bus.abort_i;
`else
    assign abort = 1'b0;
`endif
    assign bus.ready_o     = state_q == IDLE;
    assign bus.lut_en_o    = lut_en_q;
    assign bus.lut_step_o  = lut_step_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.burst_cnt_o = burst_cnt_q;
    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        bursts_d    = bursts_q;
        gap_d       = gap_q;
        div_d       = div_q;
        per_cnt_d   = per_cnt_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        div_cnt_d   = div_cnt_q;
        stop_pend_d = stop_pend_q;
        wrap        = div_cnt_q == div_q - DIV_WIDTH'(1);
        // a period ends when the step we issued lands on the generator's last sample
        per_end     = lut_step_q && bus.lut_end_i;
        burst_end   = per_end && per_cnt_q == per_q - PER_WIDTH'(1);
        burst_inc   = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + BURST_WIDTH'(1);
        last_burst  = bursts_q != '0 && burst_inc == bursts_q;
        case (state_q)
            IDLE: if (bus.start_i) begin
                state_d     = ARM;
                per_d       = (bus.cfg_periods_i == '0) ? PER_WIDTH'(1) : bus.cfg_periods_i;
                bursts_d    = bus.cfg_bursts_i;
                gap_d       = (bus.cfg_gap_i == '0) ? GAP_WIDTH'(1) : bus.cfg_gap_i;
                div_d       = (bus.cfg_step_div_i == '0) ? DIV_WIDTH'(1) : bus.cfg_step_div_i;
                burst_cnt_d = '0;
            end
            ARM: begin
                per_cnt_d = '0;
                div_cnt_d = '0;
                state_d   = abort ? FIN : RUN;
            end
            RUN: begin
                stop_pend_d = stop_pend_q || bus.stop_i;
                div_cnt_d   = wrap ? '0 : div_cnt_q + DIV_WIDTH'(1);
                if (abort) state_d = FIN;
                else if (per_end) begin
                    per_cnt_d = per_cnt_q + PER_WIDTH'(1);
                    if (burst_end) burst_cnt_d = burst_inc;
                    if (stop_pend_q || bus.stop_i || (burst_end && last_burst)) state_d = FIN;
                    else if (burst_end) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
                if (abort || bus.stop_i) state_d = FIN;
                else if (gap_cnt_q == gap_q - GAP_WIDTH'(1)) begin
                    state_d   = RUN;
                    per_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end
            FIN: begin
                stop_pend_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        lut_en_d   = state_d == RUN;
        // no step on the first RUN cycle: the divider has just been cleared
        lut_step_d = state_q == RUN && state_d == RUN && wrap;
        busy_d     = state_d inside {ARM, RUN, GAP};
        done_d     = state_d == FIN;
    end
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q                                   <= IDLE;
            {per_q, bursts_q, gap_q, div_q}           <= '0;
            {per_cnt_q, burst_cnt_q, gap_cnt_q}       <= '0;
            div_cnt_q                                 <= '0;
            {stop_pend_q, lut_en_q, lut_step_q}       <= '0;
            {busy_q, done_q}                          <= '0;
        end else begin
            state_q                                   <= state_d;
            {per_q, bursts_q, gap_q, div_q}           <= {per_d, bursts_d, gap_d, div_d};
            {per_cnt_q, burst_cnt_q, gap_cnt_q}       <= {per_cnt_d, burst_cnt_d, gap_cnt_d};
            div_cnt_q                                 <= div_cnt_d;
            {stop_pend_q, lut_en_q, lut_step_q}       <= {stop_pend_d, lut_en_d, lut_step_d};
            {busy_q, done_q}                          <= {busy_d, done_d};
        end
    end
endmodule

// File: tb/tb_wvf_burst_sequencer.sv
// tb_wvf_burst_sequencer: directed scoreboard bench for the burst sequencer with a LUT generator model
module tb_wvf_burst_sequencer;
    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       en;
        logic       step;
        logic       done;
        logic [7:0] bcnt;
    } obs_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         endn = 8;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] last_bcnt = 8'd0;
    logic [7:0] phase;
    obs_t       exp_q[$];
    always #5 clk = ~clk;
    wvf_burst_sequencer_if bif ();
    wvf_burst_sequencer dut (
        .clk_sys_i(clk),
        .rst_i    (rst),
        .bus      (bif)
    );
    // generator model: phase advances on each step, held at 0 while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= '0;
        else if (!bif.lut_en_o) phase <= '0;
        else if (bif.lut_step_o) phase <= (int'(phase) == endn - 1) ? 8'd0 : phase + 8'd1;
    end
    assign bif.lut_end_i = int'(phase) == endn - 1;
    function automatic obs_t mk(logic r, logic bz, logic e, logic s, logic dn, logic [7:0] cnt);
        return {r, bz, e, s, dn, cnt};
    endfunction
    function automatic obs_t sample();
        return {bif.ready_o, bif.busy_o, bif.lut_en_o, bif.lut_step_o, bif.done_o, bif.burst_cnt_o};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // builds the expected per-cycle trace (cycle 0 = START cycle), then drives and compares cycle by cycle
    task automatic run_seq(input string name, input int per, input int bursts, input int gap, input int div,
                           input int en_n, input int stop_c, input int restart_c,
                           output int steps, output int dones);
        int   p, d, g, c, b, n, j;
        bit   fin, stp;
        obs_t e;
        p = (per == 0) ? 1 : per;
        d = (div == 0) ? 1 : div;
        g = (gap == 0) ? 1 : gap;
        exp_q.delete();
        exp_q.push_back(mk(1, 0, 0, 0, 0, last_bcnt));
        exp_q.push_back(mk(0, 1, 0, 0, 0, 8'd0));
        c = 2;
        b = 0;
        fin = 0;
        while (!fin && c < 20000) begin
            n = 0;
            j = 0;
            while (c < 20000) begin
                stp = j > 0 && j % d == 0;
                exp_q.push_back(mk(0, 1, 1, stp, 0, 8'(b)));
                c++;
                j++;
                if (stp) begin
                    n++;
                    if (n % en_n == 0) begin
                        if (stop_c >= 0 && stop_c <= c - 1) fin = 1;
                        if (n == p * en_n) begin
                            b = (b == 255) ? 255 : b + 1;
                            if (bursts != 0 && b == bursts) fin = 1;
                            break;
                        end
                        if (fin) break;
                    end
                end
            end
            for (int k = 0; k < g && !fin; k++) begin
                exp_q.push_back(mk(0, 1, 0, 0, 0, 8'(b)));
                if (c == stop_c) fin = 1;
                c++;
            end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 1, 8'(b)));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 8'(b)));
        last_bcnt = 8'(b);
        endn = en_n;
        steps = 0;
        dones = 0;
        c = 0;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            bif.start_i = c == 0 || c == restart_c;
            bif.stop_i  = c == stop_c;
            if (c == 0) begin
                bif.cfg_periods_i  = 8'(per);
                bif.cfg_bursts_i   = 8'(bursts);
                bif.cfg_gap_i      = 16'(gap);
                bif.cfg_step_div_i = 12'(div);
            end else begin
                bif.cfg_periods_i  = 8'($urandom);
                bif.cfg_bursts_i   = 8'($urandom);
                bif.cfg_gap_i      = 16'($urandom);
                bif.cfg_step_div_i = 12'($urandom);
            end
            e = exp_q.pop_front();
            chk($sformatf("%s cyc%0d", name, c), 32'(sample()), 32'(e));
            steps += int'(bif.lut_step_o);
            dones += int'(bif.done_o);
            @(negedge clk);
            c++;
        end
        bif.start_i = 1'b0;
        bif.stop_i  = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "timeout");
    end
    initial begin
        int   steps, dones, cnt;
        bit   found;
        bif.start_i        = 1'b0;
        bif.stop_i         = 1'b0;
        bif.cfg_periods_i  = '0;
        bif.cfg_bursts_i   = '0;
        bif.cfg_gap_i      = '0;
        bif.cfg_step_div_i = '0;
`ifdef WVF_SEQ_ABORT_EN
        bif.abort_i        = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(bif.ready_o), 32'd1);
        chk("rst lut_en", 32'(bif.lut_en_o), 32'd0);
        chk("rst lut_step", 32'(bif.lut_step_o), 32'd0);
        chk("rst busy", 32'(bif.busy_o), 32'd0);
        chk("rst done", 32'(bif.done_o), 32'd0);
        chk("rst burst_cnt", 32'(bif.burst_cnt_o), 32'd0);
        rst = 1'b0;
        // single burst: 2 periods of 8 steps, step every 3 cycles
        run_seq("single", 2, 1, 5, 3, 8, -1, -1, steps, dones);
        chk("single steps", 32'(steps), 32'd16);
        chk("single dones", 32'(dones), 32'd1);
        // three bursts with 4-cycle gaps, START re-pulsed while busy
        run_seq("multi", 1, 3, 4, 2, 4, -1, 6, steps, dones);
        chk("multi steps", 32'(steps), 32'd12);
        chk("multi dones", 32'(dones), 32'd1);
        // zero substitution: periods/div/gap all 0
        run_seq("zero", 0, 2, 0, 0, 3, -1, -1, steps, dones);
        chk("zero steps", 32'(steps), 32'd6);
        // continuous, STOP mid-period in RUN
        run_seq("stop_run", 3, 0, 3, 2, 4, 7, -1, steps, dones);
        chk("stop_run steps", 32'(steps), 32'd4);
        // continuous, STOP during GAP
        run_seq("stop_gap", 1, 0, 6, 1, 2, 7, -1, steps, dones);
        chk("stop_gap dones", 32'(dones), 32'd1);
        // STOP in the same cycle as a period completion
        run_seq("stop_same", 2, 0, 2, 1, 2, 4, -1, steps, dones);
        chk("stop_same steps", 32'(steps), 32'd2);
        // reset in the middle of the second burst
        endn = 2;
        @(negedge clk);
        bif.cfg_periods_i  = 8'd1;
        bif.cfg_bursts_i   = 8'd3;
        bif.cfg_gap_i      = 16'd2;
        bif.cfg_step_div_i = 12'd2;
        bif.start_i        = 1'b1;
        @(negedge clk);
        bif.start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = bif.burst_cnt_o == 8'd1 && bif.lut_en_o;
        end
        chk("rst_mid reached burst 2", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid lut_en", 32'(bif.lut_en_o), 32'd0);
        chk("rst_mid busy", 32'(bif.busy_o), 32'd0);
        chk("rst_mid ready", 32'(bif.ready_o), 32'd1);
        chk("rst_mid burst_cnt", 32'(bif.burst_cnt_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(bif.done_o);
        end
        chk("rst_mid no done", 32'(cnt), 32'd0);
        last_bcnt = 8'd0;
`ifdef WVF_SEQ_ABORT_EN
        // ABORT together with STOP in RUN
        endn = 4;
        @(negedge clk);
        bif.cfg_periods_i  = 8'd2;
        bif.cfg_bursts_i   = 8'd0;
        bif.cfg_gap_i      = 16'd2;
        bif.cfg_step_div_i = 12'd2;
        bif.start_i        = 1'b1;
        @(negedge clk);
        bif.start_i = 1'b0;
        repeat (4) @(negedge clk);
        bif.abort_i = 1'b1;
        bif.stop_i  = 1'b1;
        @(negedge clk);
        bif.abort_i = 1'b0;
        bif.stop_i  = 1'b0;
        chk("abort lut_en", 32'(bif.lut_en_o), 32'd0);
        chk("abort lut_step", 32'(bif.lut_step_o), 32'd0);
        cnt = int'(bif.done_o);
        @(negedge clk);
        cnt += int'(bif.done_o);
        chk("abort dones", 32'(cnt), 32'd1);
        repeat (2) @(negedge clk);
        chk("abort ready", 32'(bif.ready_o), 32'd1);
        chk("abort burst_cnt", 32'(bif.burst_cnt_o), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
